handshake_tx: RTL and testbench

- Ready/valid transmitter: the active driving end of the `handshake_valid`/`handshake_ready` interface that the bound RTL monitors check.
- Accepts `in1`/`in2` operand pairs from an upstream ready/valid port and queues them in a DEPTH-entry FIFO.
- Presents each entry downstream with a valid held stable until accepted.
- Tracks downstream stall time and flags a timeout; sits between stimulus logic and the monitored RTL.

---
 rtl/handshake_tx_pkg.sv | 23 ++
 rtl/handshake_tx_if.sv | 26 ++
 rtl/handshake_tx_fifo.sv | 63 ++++++
 rtl/handshake_tx.sv | 154 +++++++++++++++
 tb/tb_handshake_tx.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/handshake_tx_pkg.sv
// Shared types for the handshake_tx ready/valid transmitter: FSM states,
// the queued entry layout at the default operand width, and the tag helper.
package handshake_tx_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic                     tag;
    logic [DEFAULT_WIDTH-1:0] in2;
    logic [DEFAULT_WIDTH-1:0] in1;
  } entry_t;

  // Tag is the OR-reduction of operand A; callers zero-extend, which leaves the OR unchanged.
  function automatic logic calc_tag(input logic [63:0] operand);
    return |operand;
  endfunction

endpackage

// File: rtl/handshake_tx_if.sv
// Downstream ready/valid bus of handshake_tx: the transmitter drives the
// master side, the monitored RTL (or a bench) sits on the slave side.
interface handshake_tx_if #(
  parameter int WIDTH = 4
);

  logic               handshake_valid;
  logic               handshake_ready;
  logic [2*WIDTH-1:0] out_data;
  logic               out;

  modport master (
    output handshake_valid,
    output out_data,
    output out,
    input  handshake_ready
  );

  modport slave (
    input  handshake_valid,
    input  out_data,
    input  out,
    output handshake_ready
  );

endinterface

// File: rtl/handshake_tx_fifo.sv
// DEPTH-entry circular queue for handshake_tx; occupancy includes the head
// currently presented downstream, and flush keeps only that head.
module handshake_tx_fifo #(
  parameter  int DEPTH   = 4,
  parameter  int ENTRY_W = 9,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               ASYNCRESET,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] push_data,
  output logic [ENTRY_W-1:0] next_data,
  output logic [CNT_W-1:0]   count,
  output logic               full
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               write_en;

  assign write_en  = push && !flush;
  assign full      = (count == CNT_W'(DEPTH));
  assign next_data = mem[rd_ptr + PTR_W'(1)];

  // NOTE: storage has no reset; count gates every read, so stale contents are never presented.
  always_ff @(posedge CLK) begin
    if (write_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (flush) begin
        // Only the presented head survives, and only if it is not being consumed now.
        wr_ptr <= (count != '0) ? rd_ptr + PTR_W'(1) : rd_ptr;
        count  <= ((count != '0) && !pop) ? CNT_W'(1) : '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/handshake_tx.sv
// Ready/valid transmitter: queues {in2, in1} beats and presents them downstream
// with a stable valid; define HANDSHAKE_TX_ASSERT_EN to embed protocol checkers.
module handshake_tx
  import handshake_tx_pkg::*;
#(
  parameter  int WIDTH   = DEFAULT_WIDTH,
  parameter  int DEPTH   = 4,
  parameter  int TIMEOUT = 15,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               ASYNCRESET,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               flush,
  handshake_tx_if.master     hs,
  output logic [CNT_W-1:0]   count,
  output logic               stall_timeout
);

  // Same layout as entry_t, sized by this instance's WIDTH.
  typedef struct packed {
    logic             tag;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in1;
  } beat_t;

  localparam int               ENTRY_W   = $bits(beat_t);
  localparam int               ST_W      = $clog2(TIMEOUT + 1);
  localparam logic [ST_W-1:0]  STALL_MAX = ST_W'(TIMEOUT);

  state_t          state;
  state_t          state_next;
  beat_t           push_beat;
  beat_t           next_beat;
  beat_t           head_q;
  logic            valid;
  logic            push;
  logic            pop;
  logic            full;
  logic            load_push;
  logic            load_next;
  logic [ST_W-1:0] stall_cnt;
  logic [ST_W-1:0] stall_next;

  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign valid     = (state == SEND);
  assign pop       = valid && hs.handshake_ready;
  assign push_beat = '{tag: calc_tag(64'(in1)), in2: in2, in1: in1};

  handshake_tx_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_data  (push_beat),
    .next_data  (next_beat),
    .count      (count),
    .full       (full)
  );

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    load_push  = 1'b0;
    load_next  = 1'b0;
    case (state)
      IDLE: begin
        if (push && !flush) begin
          state_next = SEND;
          load_push  = 1'b1;
        end
      end
      SEND: begin
        if (pop) begin
          if (flush) begin
            state_next = IDLE;
          end else if (count > CNT_W'(1)) begin
            load_next = 1'b1;
          end else if (push) begin
            // Bypass keeps the stream bubble-free when the queue held only the head.
            load_push = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      head_q <= '0;
    end else if (load_push) begin
      head_q <= push_beat;
    end else if (load_next) begin
      head_q <= next_beat;
    end
  end

  always_comb begin
    stall_next = '0;
    if (valid && !hs.handshake_ready) begin
      stall_next = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + ST_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      stall_cnt     <= stall_next;
      stall_timeout <= (stall_next == STALL_MAX);
    end
  end

  assign hs.handshake_valid = valid;
  assign hs.out_data        = {head_q.in2, head_q.in1};
  assign hs.out             = head_q.tag;

`ifdef HANDSHAKE_TX_ASSERT_EN
  a_hold_stable: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    valid && !hs.handshake_ready |=> valid && $stable(hs.out_data) && $stable(hs.out));

  a_no_push_full: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    !(push && (count == CNT_W'(DEPTH))));

  a_count_bound: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    count <= CNT_W'(DEPTH));

  a_timeout_valid: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    stall_timeout |-> valid);
`else
  // Checkers excluded from this build; datapath and control are unaffected.
`endif

endmodule

// File: tb/tb_handshake_tx.sv
// Self-checking bench for handshake_tx: a queue-based model checked every cycle,
// plus directed vectors with hand-computed values.
module tb_handshake_tx;
  import handshake_tx_pkg::*;

  localparam int WIDTH   = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic                         CLK = 1'b0;
  logic                         ASYNCRESET;
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             in1;
  logic [WIDTH-1:0]             in2;
  logic                         flush;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         stall_timeout;

  int vectors = 0;
  int errors  = 0;

  handshake_tx_if #(.WIDTH(WIDTH)) hs_if ();

  handshake_tx #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK           (CLK),
    .ASYNCRESET    (ASYNCRESET),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in1           (in1),
    .in2           (in2),
    .flush         (flush),
    .hs            (hs_if),
    .count         (count),
    .stall_timeout (stall_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic f, input logic r);
    in_valid              = v;
    in1                   = a;
    in2                   = b;
    flush                 = f;
    hs_if.handshake_ready = r;
  endtask

  // Model: the queue holds every accepted beat; element 0 is the one presented downstream.
  entry_t model_q[$];
  int     model_stall;
  bit     m_was_valid;
  bit     m_accept;
  bit     m_take;
  entry_t m_entry;

  always @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      model_q.delete();
      model_stall = 0;
    end else begin
      m_was_valid = (model_q.size() != 0);
      m_accept    = in_valid && (model_q.size() < DEPTH);
      m_take      = m_was_valid && hs_if.handshake_ready;
      if (m_was_valid && !hs_if.handshake_ready)
        model_stall = (model_stall < TIMEOUT) ? model_stall + 1 : TIMEOUT;
      else
        model_stall = 0;
      if (flush) begin
        if (m_take || !m_was_valid) model_q.delete();
        else while (model_q.size() > 1) void'(model_q.pop_back());
      end else begin
        if (m_take) void'(model_q.pop_front());
        if (m_accept) begin
          m_entry.tag = |in1;
          m_entry.in2 = in2;
          m_entry.in1 = in1;
          model_q.push_back(m_entry);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!ASYNCRESET) begin
      check("cmp_valid", 32'(hs_if.handshake_valid), 32'(model_q.size() != 0));
      check("cmp_count", 32'(count), model_q.size());
      check("cmp_in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
      check("cmp_timeout", 32'(stall_timeout), 32'(model_stall == TIMEOUT));
      if (model_q.size() != 0) begin
        check("cmp_data", 32'(hs_if.out_data), 32'({model_q[0].in2, model_q[0].in1}));
        check("cmp_tag", 32'(hs_if.out), 32'(model_q[0].tag));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ASYNCRESET = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    check("rst_valid", 32'(hs_if.handshake_valid), 0);
    check("rst_data", 32'(hs_if.out_data), 0);
    check("rst_tag", 32'(hs_if.out), 0);
    check("rst_count", 32'(count), 0);
    check("rst_timeout", 32'(stall_timeout), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    ASYNCRESET = 1'b0;
    @(negedge CLK);

    // Single beat with ready already high.
    drive(1'b1, 4'h3, 4'hA, 1'b0, 1'b1);
    @(negedge CLK);
    in_valid = 1'b0;
    check("t1_valid", 32'(hs_if.handshake_valid), 1);
    check("t1_data", 32'(hs_if.out_data), 32'h A3);
    check("t1_tag", 32'(hs_if.out), 1);
    @(negedge CLK);
    check("t1_idle_valid", 32'(hs_if.handshake_valid), 0);
    check("t1_idle_count", 32'(count), 0);

    // Backpressure and stall timeout.
    drive(1'b1, 4'h0, 4'h5, 1'b0, 1'b0);
    @(negedge CLK);
    in_valid = 1'b0;
    check("t2_data", 32'(hs_if.out_data), 32'h50);
    check("t2_tag", 32'(hs_if.out), 0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (i == 14) check("t2_timeout_pre", 32'(stall_timeout), 0);
      if (i == 15) check("t2_timeout_set", 32'(stall_timeout), 1);
    end
    check("t2_hold_data", 32'(hs_if.out_data), 32'h50);
    check("t2_hold_valid", 32'(hs_if.handshake_valid), 1);
    check("t2_timeout_sat", 32'(stall_timeout), 1);
    hs_if.handshake_ready = 1'b1;
    @(negedge CLK);
    hs_if.handshake_ready = 1'b0;
    check("t2_timeout_clr", 32'(stall_timeout), 0);
    check("t2_popped", 32'(hs_if.handshake_valid), 0);

    // Fill to DEPTH, then attempt pushes while full (with and without a pop).
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i), 4'(i + 8), 1'b0, 1'b0);
      @(negedge CLK);
    end
    check("t3_full_count", 32'(count), 4);
    check("t3_full_ready", 32'(in_ready), 0);
    drive(1'b1, 4'h5, 4'hD, 1'b0, 1'b0);
    @(negedge CLK);
    check("t3_ignored_count", 32'(count), 4);
    check("t3_first_beat", 32'(hs_if.out_data), 32'h91);
    drive(1'b1, 4'h6, 4'hE, 1'b0, 1'b1);
    @(negedge CLK);
    in_valid = 1'b0;
    check("t3_full_pop_count", 32'(count), 3);
    for (int i = 2; i <= 4; i++) begin
      check("t3_beat", 32'(hs_if.out_data), 32'({4'(i + 8), 4'(i)}));
      @(negedge CLK);
    end
    check("t3_drained_valid", 32'(hs_if.handshake_valid), 0);
    check("t3_drained_count", 32'(count), 0);

    // Streaming: one beat per cycle across several pointer wraps.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 4'(i), 4'hC, 1'b0, 1'b1);
      @(negedge CLK);
      check("t4_valid", 32'(hs_if.handshake_valid), 1);
      check("t4_data", 32'(hs_if.out_data), 32'({4'hC, 4'(i)}));
      check("t4_count", 32'(count), 1);
    end
    in_valid = 1'b0;
    @(negedge CLK);
    check("t4_end_valid", 32'(hs_if.handshake_valid), 0);

    // Flush behind a stalled head, with a same-cycle push that must be dropped.
    drive(1'b1, 4'h1, 4'h7, 1'b0, 1'b0);
    @(negedge CLK);
    drive(1'b1, 4'h2, 4'h7, 1'b0, 1'b0);
    @(negedge CLK);
    drive(1'b1, 4'h3, 4'h7, 1'b0, 1'b0);
    @(negedge CLK);
    check("t5_queued", 32'(count), 3);
    drive(1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
    @(negedge CLK);
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    check("t5_flush_count", 32'(count), 1);
    check("t5_flush_head", 32'(hs_if.out_data), 32'h71);
    @(negedge CLK);
    check("t5_head_held", 32'(hs_if.out_data), 32'h71);
    hs_if.handshake_ready = 1'b1;
    @(negedge CLK);
    hs_if.handshake_ready = 1'b0;
    check("t5_after_valid", 32'(hs_if.handshake_valid), 0);
    check("t5_after_count", 32'(count), 0);

    // Flush together with a pop empties everything.
    drive(1'b1, 4'h8, 4'h2, 1'b0, 1'b0);
    @(negedge CLK);
    drive(1'b1, 4'h9, 4'h2, 1'b0, 1'b0);
    @(negedge CLK);
    in_valid = 1'b0;
    check("t5b_queued", 32'(count), 2);
    drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
    @(negedge CLK);
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    check("t5b_valid", 32'(hs_if.handshake_valid), 0);
    check("t5b_count", 32'(count), 0);

    // Asynchronous reset in the middle of a timed-out stall.
    drive(1'b1, 4'h6, 4'h4, 1'b0, 1'b0);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (16) @(negedge CLK);
    check("t6_pre_timeout", 32'(stall_timeout), 1);
    #2 ASYNCRESET = 1'b1;
    #1;
    check("t6_valid", 32'(hs_if.handshake_valid), 0);
    check("t6_count", 32'(count), 0);
    check("t6_timeout", 32'(stall_timeout), 0);
    check("t6_in_ready", 32'(in_ready), 1);
    check("t6_data", 32'(hs_if.out_data), 0);
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    @(negedge CLK);
    drive(1'b1, 4'h9, 4'h1, 1'b0, 1'b1);
    @(negedge CLK);
    in_valid = 1'b0;
    check("t6_beat_data", 32'(hs_if.out_data), 32'h19);
    check("t6_beat_tag", 32'(hs_if.out), 1);
    @(negedge CLK);
    check("t6_beat_done", 32'(hs_if.handshake_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
